// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-rate divider, col/row counters and registered sync/blank decode.
// Decoded outputs are computed from next-state counter values, so they never lag col/row.
module vga_sync_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       CLK,
  input  logic       RST,
  output logic [9:0] col,
  output logic [9:0] row,
  output logic       hsync,
  output logic       vsync,
  output logic       vnotactive,
  output logic       display_on,
  output logic       pix_tick,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [9:0] COL_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] ROW_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [3:0] div_q, div_d;
  logic [9:0] col_q, col_d;
  logic [9:0] row_q, row_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       vnotactive_q, vnotactive_d;
  logic       display_on_q, display_on_d;
  logic       pix_tick_q, pix_tick_d;
  logic       frame_start_q, frame_start_d;

  always_comb begin
    pix_tick_d    = (div_q == DIV_LAST);
    div_d         = pix_tick_d ? 4'd0 : div_q + 4'd1;
    col_d         = col_q;
    row_d         = row_q;
    frame_start_d = 1'b0;
    if (pix_tick_d) begin
      if (col_q == COL_LAST) begin
        col_d = 10'd0;
        if (row_q == ROW_LAST) begin
          row_d         = 10'd0;
          frame_start_d = 1'b1;
        end else begin
          row_d = row_q + 10'd1;
        end
      end else begin
        col_d = col_q + 10'd1;
      end
    end
    // Decode the values col/row will hold next cycle so flags line up with them.
    hsync_d      = !((col_d >= HS_START) && (col_d < HS_END));
    vsync_d      = !((row_d >= VS_START) && (row_d < VS_END));
    vnotactive_d = (row_d >= V_ACT);
    display_on_d = (col_d < H_ACT) && (row_d < V_ACT);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      div_q         <= 4'd0;
      col_q         <= 10'd0;
      row_q         <= 10'd0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      vnotactive_q  <= 1'b0;
      display_on_q  <= 1'b1;
      pix_tick_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      col_q         <= col_d;
      row_q         <= row_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      vnotactive_q  <= vnotactive_d;
      display_on_q  <= display_on_d;
      pix_tick_q    <= pix_tick_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign col         = col_q;
  assign row         = row_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign vnotactive  = vnotactive_q;
  assign display_on  = display_on_q;
  assign pix_tick    = pix_tick_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default geometry plus two reduced geometries (CLK_DIV 2 and 1)
// checked against a per-cycle reference model through a scoreboard queue.
module tb_vga_sync_gen;

  typedef struct packed {
    logic [9:0] col;
    logic [9:0] row;
    logic       hs;
    logic       vs;
    logic       vna;
    logic       don;
    logic       tick;
    logic       fs;
  } obs_t;

  typedef struct packed {
    obs_t d;
    obs_t s;
    obs_t o;
  } trio_t;

  localparam obs_t RST_OBS = '{col: 10'd0, row: 10'd0, hs: 1'b1, vs: 1'b1,
                               vna: 1'b0, don: 1'b1, tick: 1'b0, fs: 1'b0};

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  logic [9:0] col_d, row_d, col_s, row_s, col_o, row_o;
  logic hs_d, vs_d, vna_d, don_d, tk_d, fs_d;
  logic hs_s, vs_s, vna_s, don_s, tk_s, fs_s;
  logic hs_o, vs_o, vna_o, don_o, tk_o, fs_o;

  vga_sync_gen u_def (
    .CLK(CLK), .RST(RST), .col(col_d), .row(row_d), .hsync(hs_d), .vsync(vs_d),
    .vnotactive(vna_d), .display_on(don_d), .pix_tick(tk_d), .frame_start(fs_d));

  vga_sync_gen #(.CLK_DIV(2), .H_ACTIVE(20), .H_FP(3), .H_SYNC(5), .H_BP(4),
                 .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3)) u_sm (
    .CLK(CLK), .RST(RST), .col(col_s), .row(row_s), .hsync(hs_s), .vsync(vs_s),
    .vnotactive(vna_s), .display_on(don_s), .pix_tick(tk_s), .frame_start(fs_s));

  vga_sync_gen #(.CLK_DIV(1), .H_ACTIVE(20), .H_FP(3), .H_SYNC(5), .H_BP(4),
                 .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3)) u_d1 (
    .CLK(CLK), .RST(RST), .col(col_o), .row(row_o), .hsync(hs_o), .vsync(vs_o),
    .vnotactive(vna_o), .display_on(don_o), .pix_tick(tk_o), .frame_start(fs_o));

  obs_t a_def, a_sm, a_d1;
  assign a_def = {col_d, row_d, hs_d, vs_d, vna_d, don_d, tk_d, fs_d};
  assign a_sm  = {col_s, row_s, hs_s, vs_s, vna_s, don_s, tk_s, fs_s};
  assign a_d1  = {col_o, row_o, hs_o, vs_o, vna_o, don_o, tk_o, fs_o};

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model: one entry per instance (0 = default, 1 = small/div2, 2 = small/div1).
  int P_DIV [3] = '{2, 2, 1};
  int P_HA  [3] = '{640, 20, 20};
  int P_HF  [3] = '{16, 3, 3};
  int P_HS  [3] = '{96, 5, 5};
  int P_HB  [3] = '{48, 4, 4};
  int P_VA  [3] = '{480, 12, 12};
  int P_VF  [3] = '{10, 2, 2};
  int P_VS  [3] = '{2, 2, 2};
  int P_VB  [3] = '{33, 3, 3};
  int m_div [3];
  int m_col [3];
  int m_row [3];
  bit m_tick [3];
  bit m_fs [3];
  obs_t m_exp [3];
  trio_t sb [$];

  always @(posedge CLK) begin
    int ht, vt, hs0, vs0;
    for (int i = 0; i < 3; i++) begin
      ht = P_HA[i] + P_HF[i] + P_HS[i] + P_HB[i];
      vt = P_VA[i] + P_VF[i] + P_VS[i] + P_VB[i];
      if (RST) begin
        m_div[i] = 0; m_col[i] = 0; m_row[i] = 0; m_tick[i] = 0; m_fs[i] = 0;
      end else begin
        m_tick[i] = (m_div[i] == P_DIV[i] - 1);
        m_div[i]  = m_tick[i] ? 0 : m_div[i] + 1;
        m_fs[i]   = 0;
        if (m_tick[i]) begin
          if (m_col[i] == ht - 1) begin
            m_col[i] = 0;
            if (m_row[i] == vt - 1) begin
              m_row[i] = 0;
              m_fs[i]  = 1;
            end else m_row[i]++;
          end else m_col[i]++;
        end
      end
      hs0 = P_HA[i] + P_HF[i];
      vs0 = P_VA[i] + P_VF[i];
      m_exp[i] = {10'(m_col[i]), 10'(m_row[i]),
                  !(m_col[i] >= hs0 && m_col[i] < hs0 + P_HS[i]),
                  !(m_row[i] >= vs0 && m_row[i] < vs0 + P_VS[i]),
                  m_row[i] >= P_VA[i],
                  m_col[i] < P_HA[i] && m_row[i] < P_VA[i],
                  m_tick[i], m_fs[i]};
    end
    sb.push_back({m_exp[0], m_exp[1], m_exp[2]});
  end

  // Advance to the next falling edge and pop the model's entry for the preceding rising edge.
  task automatic cyc(output trio_t t);
    @(negedge CLK);
    if (sb.size() == 0) t = '0;
    else t = sb.pop_front();
  endtask

  task automatic test_reset();
    trio_t t;
    RST = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cyc(t);
      n_cmp++;
      if (a_def !== RST_OBS) begin n_mis++; $display("FAIL reset_def: got %p want %p", a_def, RST_OBS); end
      n_cmp++;
      if (a_sm !== RST_OBS) begin n_mis++; $display("FAIL reset_sm: got %p want %p", a_sm, RST_OBS); end
      n_cmp++;
      if (a_d1 !== RST_OBS) begin n_mis++; $display("FAIL reset_d1: got %p want %p", a_d1, RST_OBS); end
    end
    RST = 1'b0;
  endtask

  task automatic test_tick_timing();
    trio_t t;
    for (int c = 1; c <= 6; c++) begin
      cyc(t);
      n_cmp++;
      if (tk_d !== ((c % 2) == 0) || col_d !== 10'(c / 2) || row_d !== 10'd0) begin
        n_mis++;
        $display("FAIL tick_div2 cycle %0d: got tick=%b col=%0d row=%0d want tick=%b col=%0d row=0",
                 c, tk_d, col_d, row_d, (c % 2) == 0, c / 2);
      end
      n_cmp++;
      if (tk_o !== 1'b1 || col_o !== 10'(c)) begin
        n_mis++;
        $display("FAIL tick_div1 cycle %0d: got tick=%b col=%0d want tick=1 col=%0d", c, tk_o, col_o, c);
      end
      n_cmp++;
      if (a_def !== t.d) begin n_mis++; $display("FAIL tick_model_def: got %p want %p", a_def, t.d); end
    end
  endtask

  task automatic test_hsync();
    trio_t t;
    int fall_col = -1, rise_col = -1, low_px = 0;
    logic pv_hs = hs_d;
    for (int n = 0; n < 1700 && rise_col < 0; n++) begin
      cyc(t);
      n_cmp++;
      if (a_def !== t.d) begin n_mis++; $display("FAIL hsync_model: got %p want %p", a_def, t.d); end
      if (tk_d && !hs_d) low_px++;
      if (pv_hs && !hs_d) fall_col = int'(col_d);
      if (!pv_hs && hs_d) rise_col = int'(col_d);
      pv_hs = hs_d;
    end
    n_cmp++;
    if (fall_col != 656) begin n_mis++; $display("FAIL hsync_fall: got col %0d want 656", fall_col); end
    n_cmp++;
    if (rise_col != 752) begin n_mis++; $display("FAIL hsync_rise: got col %0d want 752", rise_col); end
    n_cmp++;
    if (low_px != 96) begin n_mis++; $display("FAIL hsync_width: got %0d px want 96", low_px); end
  endtask

  task automatic test_frame();
    trio_t t;
    int last_s = -1, last_o = -1, nfs_s = 0;
    int rises_s = 0, rises_o = 0, vsl_s = 0, vsl_o = 0;
    logic pv_vna_s = vna_s, pv_vna_o = vna_o, pv_fs_s = fs_s, pv_fs_o = fs_o;
    for (int n = 0; n < 4000 && nfs_s < 3; n++) begin
      cyc(t);
      n_cmp++;
      if (a_sm !== t.s) begin n_mis++; $display("FAIL frame_model_sm: got %p want %p", a_sm, t.s); end
      n_cmp++;
      if (a_d1 !== t.o) begin n_mis++; $display("FAIL frame_model_d1: got %p want %p", a_d1, t.o); end
      if (vna_s && !pv_vna_s) rises_s++;
      if (vna_o && !pv_vna_o) rises_o++;
      if (!vs_s) vsl_s++;
      if (!vs_o) vsl_o++;
      if (tk_s && col_s == 10'd0 && row_s == 10'd12) begin
        n_cmp++;
        if (vna_s !== 1'b1 || don_s !== 1'b0) begin
          n_mis++; $display("FAIL blank_entry: got vna=%b don=%b want vna=1 don=0", vna_s, don_s);
        end
      end
      if (fs_s) begin
        n_cmp++;
        if (pv_fs_s !== 1'b0 || col_s !== 10'd0 || row_s !== 10'd0 || vna_s !== 1'b0 || pv_vna_s !== 1'b1) begin
          n_mis++;
          $display("FAIL wrap_sm: got prev_fs=%b col=%0d row=%0d vna=%b prev_vna=%b want 0,0,0,0,1",
                   pv_fs_s, col_s, row_s, vna_s, pv_vna_s);
        end
        if (last_s >= 0) begin
          n_cmp++;
          if (n - last_s != 1216) begin n_mis++; $display("FAIL period_div2: got %0d want 1216", n - last_s); end
          n_cmp++;
          if (rises_s != 1) begin n_mis++; $display("FAIL vna_rises_sm: got %0d want 1", rises_s); end
          n_cmp++;
          if (vsl_s != 128) begin n_mis++; $display("FAIL vsync_low_sm: got %0d cycles want 128", vsl_s); end
        end
        last_s = n; rises_s = 0; vsl_s = 0; nfs_s++;
      end
      if (fs_o) begin
        if (last_o >= 0) begin
          n_cmp++;
          if (n - last_o != 608) begin n_mis++; $display("FAIL period_div1: got %0d want 608", n - last_o); end
          n_cmp++;
          if (rises_o != 1 || vsl_o != 64) begin
            n_mis++; $display("FAIL frame_d1: got rises=%0d vs_low=%0d want 1 and 64", rises_o, vsl_o);
          end
        end
        last_o = n; rises_o = 0; vsl_o = 0;
      end
      pv_vna_s = vna_s; pv_vna_o = vna_o; pv_fs_s = fs_s; pv_fs_o = fs_o;
    end
    n_cmp++;
    if (nfs_s < 3) begin n_mis++; $display("FAIL frame_timeout: got %0d frame_start pulses want 3", nfs_s); end
  endtask

  task automatic test_mid_reset();
    trio_t t;
    bit found = 0;
    for (int n = 0; n < 1300 && !found; n++) begin
      cyc(t);
      n_cmp++;
      if (a_sm !== t.s) begin n_mis++; $display("FAIL pre_reset_model: got %p want %p", a_sm, t.s); end
      if (t.s.col == 10'd10 && t.s.row == 10'd8) found = 1;
    end
    n_cmp++;
    if (!found) begin n_mis++; $display("FAIL mid_reset_timeout: got no (10,8) want (10,8)"); end
    RST = 1'b1;
    cyc(t);
    RST = 1'b0;
    n_cmp++;
    if (a_sm !== RST_OBS) begin n_mis++; $display("FAIL mid_reset_sm: got %p want %p", a_sm, RST_OBS); end
    n_cmp++;
    if (a_def !== RST_OBS) begin n_mis++; $display("FAIL mid_reset_def: got %p want %p", a_def, RST_OBS); end
    cyc(t);
    n_cmp++;
    if (tk_s !== 1'b0 || col_s !== 10'd0) begin
      n_mis++; $display("FAIL post_reset_c1: got tick=%b col=%0d want tick=0 col=0", tk_s, col_s);
    end
    cyc(t);
    n_cmp++;
    if (tk_s !== 1'b1 || col_s !== 10'd1 || fs_s !== 1'b0) begin
      n_mis++; $display("FAIL post_reset_c2: got tick=%b col=%0d fs=%b want tick=1 col=1 fs=0", tk_s, col_s, fs_s);
    end
    n_cmp++;
    if (a_sm !== t.s) begin n_mis++; $display("FAIL post_reset_model: got %p want %p", a_sm, t.s); end
  endtask

  initial begin
    test_reset();
    test_tick_timing();
    test_hsync();
    test_frame();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
